fetch_controller: RTL and testbench

- Sequences the fetch stage: owns the PC register and issues one instruction-memory request at a time.
- Handles variable-latency memory responses, branch redirects and decode back-pressure.
- Presents fetched instructions to decode through a registered valid/stall output slot, backed by a one-entry skid buffer.
- Sits between the PC/adder datapath, the instruction memory port and the decode pipeline register.

---
 rtl/fetch_controller.sv | 177 +++++++++++++++++
 tb/tb_fetch_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the PC and keeps at most one instruction-memory request outstanding.
// Latency: an instruction reaches the decode slot one cycle after its ImemRValid; the memory latency itself is arbitrary.
// Backpressure: Stall holds the slot, a one-entry skid catches a response that meets a full stalled slot, and no request issues while blocked.
module fetch_controller #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}},
    parameter int unsigned      PC_STEP  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Stall,
    input  logic             ImemGnt,
    input  logic             ImemRValid,
    input  logic [WIDTH-1:0] ImemRData,
    output logic             ImemReq,
    output logic [WIDTH-1:0] ImemAddr,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCPlus4,
    output logic [WIDTH-1:0] Instr,
    output logic [WIDTH-1:0] InstrPC,
    output logic             InstrValid
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic [WIDTH-1:0] pc;
    } slot_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] req_pc;
    logic             kill_pending;
    slot_t            slot_q;
    logic             slot_vld;
    slot_t            skid_q;
    logic             skid_vld;

    logic             free;
    logic             consume;
    logic             req_c;
    logic             grant_hit;
    logic             rsp_take;
    logic             rsp_to_slot;
    logic             rsp_to_skid;
    logic             skid_drain;

    assign free    = !slot_vld || !Stall;
    assign consume = slot_vld && !Stall;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a redirect never holds the FSM back, it only marks in-flight data as dead
    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT:  state_nxt = ST_ISSUE;
            ST_ISSUE: if (grant_hit) state_nxt = ST_WAIT;
            ST_WAIT:  if (ImemRValid) state_nxt = rsp_to_skid ? ST_HOLD : ST_ISSUE;
            ST_HOLD:  if (BranchTaken || consume) state_nxt = ST_ISSUE;
            default:  state_nxt = ST_BOOT;
        endcase
    end

    // Output / action decode
    always_comb begin
        req_c       = 1'b0;
        grant_hit   = 1'b0;
        rsp_take    = 1'b0;
        rsp_to_slot = 1'b0;
        rsp_to_skid = 1'b0;
        skid_drain  = 1'b0;
        case (state)
            ST_ISSUE: begin
                req_c     = free;
                grant_hit = free && ImemGnt;
            end
            ST_WAIT: begin
                rsp_take    = ImemRValid && !kill_pending && !BranchTaken;
                rsp_to_slot = rsp_take && free;
                rsp_to_skid = rsp_take && !free;
            end
            ST_HOLD: begin
                skid_drain = consume && !BranchTaken;
            end
            default: begin
                req_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q         <= RESET_PC;
            req_pc       <= {WIDTH{1'b0}};
            kill_pending <= 1'b0;
        end else begin
            if (BranchTaken) begin
                pc_q <= BranchTarget;
            end else if (rsp_take) begin
                pc_q <= req_pc + STEP;
            end

            if (grant_hit) begin
                req_pc <= pc_q;
            end

            // A grant that coincides with a redirect belongs to the old path
            if (grant_hit) begin
                kill_pending <= BranchTaken;
            end else if (state == ST_WAIT) begin
                if (ImemRValid) begin
                    kill_pending <= 1'b0;
                end else if (BranchTaken) begin
                    kill_pending <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_q   <= '0;
            slot_vld <= 1'b0;
            skid_q   <= '0;
            skid_vld <= 1'b0;
        end else begin
            if (BranchTaken) begin
                slot_vld <= 1'b0;
            end else if (rsp_to_slot) begin
                slot_q   <= '{dat: ImemRData, pc: req_pc};
                slot_vld <= 1'b1;
            end else if (skid_drain) begin
                slot_q   <= skid_q;
                slot_vld <= 1'b1;
            end else if (consume) begin
                slot_vld <= 1'b0;
            end

            if (BranchTaken) begin
                skid_vld <= 1'b0;
            end else if (rsp_to_skid) begin
                skid_q   <= '{dat: ImemRData, pc: req_pc};
                skid_vld <= 1'b1;
            end else if (skid_drain) begin
                skid_vld <= 1'b0;
            end
        end
    end

    assign ImemReq    = req_c;
    assign ImemAddr   = pc_q;
    assign PC         = pc_q;
    assign PCPlus4    = pc_q + STEP;
    assign Instr      = slot_q.dat;
    assign InstrPC    = slot_q.pc;
    assign InstrValid = slot_vld;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios, then randomized traffic against a
// transaction-level model (expected fetch address plus queue of fetched-but-unconsumed PCs).
module tb_fetch_controller;

    logic        clock;
    logic        reset;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Stall;
    logic        ImemGnt;
    logic        ImemRValid;
    logic [31:0] ImemRData;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrValid;

    logic        w_rvalid;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;
    logic [31:0] w_instr;
    logic [31:0] w_ipc;
    logic        w_ivld;

    fetch_controller dut (
        .clock(clock), .reset(reset), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Stall(Stall), .ImemGnt(ImemGnt), .ImemRValid(ImemRValid), .ImemRData(ImemRData),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .PC(PC), .PCPlus4(PCPlus4),
        .Instr(Instr), .InstrPC(InstrPC), .InstrValid(InstrValid)
    );

    fetch_controller #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
        .clock(clock), .reset(reset), .BranchTaken(1'b0), .BranchTarget(32'h0),
        .Stall(1'b0), .ImemGnt(1'b1), .ImemRValid(w_rvalid), .ImemRData(32'h0),
        .ImemReq(w_req), .ImemAddr(w_addr), .PC(w_pc), .PCPlus4(w_pc4),
        .Instr(w_instr), .InstrPC(w_ipc), .InstrValid(w_ivld)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_consumed = 0;
    logic [31:0] q[$];
    logic [31:0] next_addr;
    logic        out_busy = 1'b0;
    logic [31:0] out_addr = 32'h0;
    int          out_cnt = 0;
    int          lat_next = 1;
    logic        spur_en = 1'b0;
    logic        w_pend = 1'b0;

    logic        s_req, s_vld, s_rvalid, s_wreq;
    logic [31:0] s_addr, s_ipc, s_instr, s_waddr;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_flush();
        q.delete();
        next_addr = 32'h0;
    endtask

    // One clock cycle: drive at posedge+1, observe and score at negedge
    task automatic tick(input logic st, input logic gt, input logic br, input logic [31:0] tg);
        Stall        = st;
        ImemGnt      = gt;
        BranchTaken  = br;
        BranchTarget = tg;
        if (out_busy && out_cnt == 0) begin
            ImemRValid = 1'b1;
            ImemRData  = mem(out_addr);
        end else if (!out_busy && spur_en && $urandom_range(0, 9) == 0) begin
            ImemRValid = 1'b1;
            ImemRData  = $urandom;
        end else begin
            ImemRValid = 1'b0;
            ImemRData  = $urandom;
        end
        w_rvalid = w_pend;
        @(negedge clock);
        s_req = ImemReq;  s_addr = ImemAddr; s_vld = InstrValid;
        s_ipc = InstrPC;  s_instr = Instr;   s_rvalid = ImemRValid;
        s_wreq = w_req;   s_waddr = w_addr;
        if (reset) begin
            if (out_busy) check("one_outstanding", ImemReq, 1'b0);
            if (InstrValid && !Stall) begin
                n_cmp++;
                assert (q.size() != 0) else begin
                    n_bad++;
                    $error("FAIL consume_unexpected observed=%h expected=none", InstrPC);
                end
                if (q.size() != 0) begin
                    check("consume_pc", InstrPC, q[0]);
                    check("consume_instr", Instr, mem(q[0]));
                    void'(q.pop_front());
                    n_consumed++;
                end
            end
            if (ImemReq && ImemGnt) begin
                check("req_addr", ImemAddr, next_addr);
                if (!BranchTaken) begin
                    q.push_back(next_addr);
                    next_addr = next_addr + 32'd4;
                end
            end
            if (BranchTaken) begin
                q.delete();
                next_addr = BranchTarget;
            end
        end
        if (out_busy) begin
            if (ImemRValid) out_busy = 1'b0;
            else out_cnt--;
        end
        if (reset && ImemReq && ImemGnt) begin
            out_busy = 1'b1;
            out_addr = ImemAddr;
            out_cnt  = lat_next - 1;
        end
        w_pend = reset && w_req;
        @(posedge clock);
        #1;
    endtask

    initial begin
        clock = 1'b0; reset = 1'b1;
        BranchTaken = 1'b0; BranchTarget = 32'h0; Stall = 1'b0;
        ImemGnt = 1'b0; ImemRValid = 1'b0; ImemRData = 32'h0; w_rvalid = 1'b0;
        #2 reset = 1'b0;
        model_flush();
        #1;
        check("rst_valid", InstrValid, 1'b0);
        check("rst_instr", Instr, 32'h0);
        check("rst_ipc", InstrPC, 32'h0);
        check("rst_req", ImemReq, 1'b0);
        check("rst_pc", PC, 32'h0);
        check("rst_pc4", PCPlus4, 32'h4);
        check("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
        check("rst_wrap_pc4", w_pc4, 32'h0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;

        // Sequential fetch, no stall, one-cycle memory
        tick(0, 1, 0, 0);  check("boot_req", s_req, 1'b0);
        tick(0, 1, 0, 0);  check("c1_req", s_req, 1'b1);  check("c1_addr", s_addr, 32'h0);
                           check("wrap_addr0", s_waddr, 32'hFFFF_FFFC);
        tick(0, 1, 0, 0);  check("c2_rvalid", s_rvalid, 1'b1); check("c2_vld", s_vld, 1'b0);
        tick(0, 1, 0, 0);  check("c3_vld", s_vld, 1'b1); check("c3_ipc", s_ipc, 32'h0);
                           check("c3_instr", s_instr, mem(32'h0)); check("c3_addr", s_addr, 32'h4);
                           check("wrap_req1", s_wreq, 1'b1); check("wrap_addr1", s_waddr, 32'h0);
        tick(0, 1, 0, 0);  check("c4_vld", s_vld, 1'b0);

        // Slot holding PC 4 under a three-cycle stall
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 0, 0);
            check("stall_req", s_req, 1'b0);
            check("stall_vld", s_vld, 1'b1);
            check("stall_ipc", s_ipc, 32'h4);
        end
        tick(0, 1, 0, 0);  check("unstall_req", s_req, 1'b1); check("unstall_addr", s_addr, 32'h8);
        tick(0, 1, 0, 0);  check("c9_vld", s_vld, 1'b0);
        lat_next = 3;
        tick(0, 1, 0, 0);  check("c10_ipc", s_ipc, 32'h8); check("c10_addr", s_addr, 32'hC);

        // Redirect while waiting; the stale response lands two cycles later
        tick(0, 1, 1, 32'h100);
        tick(0, 1, 0, 0);  check("kill_vld_a", s_vld, 1'b0); check("kill_req", s_req, 1'b0);
        tick(0, 1, 0, 0);  check("kill_rvalid", s_rvalid, 1'b1); check("kill_vld_b", s_vld, 1'b0);
        lat_next = 1;
        tick(0, 1, 0, 0);  check("redir_addr", s_addr, 32'h100); check("redir_vld", s_vld, 1'b0);
        tick(0, 1, 0, 0);
        lat_next = 2;

        // Redirect coincident with a grant
        tick(0, 1, 1, 32'h40);
                           check("br_slot_ipc", s_ipc, 32'h100); check("br_slot_instr", s_instr, mem(32'h100));
                           check("br_grant_addr", s_addr, 32'h104);
        tick(0, 1, 0, 0);  check("brg_vld_a", s_vld, 1'b0);
        tick(0, 1, 0, 0);  check("brg_vld_b", s_vld, 1'b0);
        lat_next = 1;
        tick(0, 1, 0, 0);  check("brg_addr", s_addr, 32'h40); check("brg_req", s_req, 1'b1);
        tick(0, 1, 0, 0);
        lat_next = 3;
        tick(0, 1, 0, 0);  check("c21_ipc", s_ipc, 32'h40); check("c21_addr", s_addr, 32'h44);

        // Reset with a request in flight
        reset = 1'b0;
        model_flush();
        #1;
        check("mrst_valid", InstrValid, 1'b0);
        check("mrst_ipc", InstrPC, 32'h0);
        check("mrst_instr", Instr, 32'h0);
        check("mrst_pc", PC, 32'h0);
        check("mrst_req", ImemReq, 1'b0);
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        reset = 1'b1;
        lat_next = 1;
        tick(0, 1, 0, 0);  check("stale_rvalid", s_rvalid, 1'b1); check("stale_req", s_req, 1'b0);
        tick(0, 1, 0, 0);  check("post_addr", s_addr, 32'h0); check("post_req", s_req, 1'b1);
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);  check("post_vld", s_vld, 1'b1); check("post_ipc", s_ipc, 32'h0);
                           check("post_instr", s_instr, mem(32'h0));

        // Randomized traffic
        spur_en = 1'b1;
        n_consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            logic st, gt, br;
            logic [31:0] tg;
            lat_next = $urandom_range(1, 4);
            st = ($urandom_range(0, 9) < 3);
            gt = ($urandom_range(0, 9) < 7);
            br = ($urandom_range(0, 19) == 0);
            tg = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
            tick(st, gt, br, tg);
        end
        for (int i = 0; i < 12; i++) tick(0, 0, 0, 0);
        check("drain_queue_empty", q.size(), 0);
        check("drain_slot_empty", s_vld, 1'b0);
        check("rand_liveness", n_consumed >= 100, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
